// File: rtl/div_share_pkg.sv
// Shared types and default sizes for the divider-sharing controller.
package div_share_pkg;

  localparam int WIDTH_C       = 14;
  localparam int DIV_LATENCY_C = 7;
  localparam int NUM_REQ_C     = 4;
  localparam int TAG_W_C       = $clog2(NUM_REQ_C);

  // Tag width follows the default requester count; widen TAG_W_C if NUM_REQ grows.
  typedef logic [TAG_W_C-1:0] tag_t;

  // One shadow stage travelling alongside the divider pipeline.
  typedef struct packed {
    logic valid;
    tag_t tag;
    logic dbz;
  } shadow_stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past each winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand;

  // First requester at or after the pointer wins; pointer advances to winner+1.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (en_i && !gnt_vld_o && req_i[cand]) begin
        gnt_vld_o   = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (gnt_vld_o)
      ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one pipelined divider among NUM_REQ requesters. A shadow pipeline of
// {valid, tag, dbz} runs in lockstep with the divider (same pause) and steers
// each quotient back to its requester; the divider's own valid is never used.
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_C,
  parameter int WIDTH       = WIDTH_C,
  parameter int DIV_LATENCY = DIV_LATENCY_C,
  parameter int TAG_W       = $clog2(NUM_REQ)
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic [NUM_REQ-1:0]               req_valid_in,
  input  logic [NUM_REQ*WIDTH-1:0]         req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0]         req_divisor_in,
  output logic [NUM_REQ-1:0]               req_ready_out,
  output logic [NUM_REQ-1:0]               res_valid_out,
  output logic [WIDTH-1:0]                 res_quotient_out,
  output logic                             res_dbz_out,
  input  logic [NUM_REQ-1:0]               res_ready_in,
  output logic [WIDTH-1:0]                 div_dividend_out,
  output logic [WIDTH-1:0]                 div_divisor_out,
  output logic                             div_valid_out,
  output logic                             div_pause_out,
  input  logic [WIDTH-1:0]                 div_quotient_in,
  output logic [$clog2(DIV_LATENCY+1)-1:0] inflight_out
);

  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  logic               arb_en;
  logic [NUM_REQ-1:0] gnt;
  logic [TAG_W-1:0]   gnt_idx;
  logic               gnt_vld;

  shadow_stage_t      shadow_q [DIV_LATENCY];
  shadow_stage_t      s0_d;
  shadow_stage_t      tail;

  logic [WIDTH-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;

  assign tail = shadow_q[DIV_LATENCY-1];

  // Freeze everything while the completing result's owner cannot take it.
  assign div_pause_out = tail.valid & ~res_ready_in[tail.tag];

  // No issue while paused, and nothing leaks out while reset is held.
  assign arb_en = ~div_pause_out & rst_n_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_arb (
    .clk_i     (clk_in),
    .rst_n_i   (rst_n_in),
    .en_i      (arb_en),
    .req_i     (req_valid_in),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  assign req_ready_out = gnt;
  assign div_valid_out = gnt_vld;

  // Operand mux from the winner; with no grant the last operands are held.
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    if (gnt_vld) begin
      dvd_d = req_dividend_in[int'(gnt_idx)*WIDTH +: WIDTH];
      dvs_d = req_divisor_in[int'(gnt_idx)*WIDTH +: WIDTH];
    end
  end

  assign div_dividend_out = dvd_d;
  assign div_divisor_out  = dvs_d;

  // Operand hold register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dvd_q <= '0;
      dvs_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
    end
  end

  // Entry into the shadow pipeline for this cycle's issue (or a bubble).
  always_comb begin
    s0_d       = '0;
    s0_d.valid = gnt_vld;
    s0_d.tag   = tag_t'(gnt_idx);
    s0_d.dbz   = gnt_vld & (dvs_d == '0);
  end

  // Shadow pipeline, shifting only on the same cycles the divider advances.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DIV_LATENCY; i++) shadow_q[i] <= '0;
    end else if (!div_pause_out) begin
      shadow_q[0] <= s0_d;
      for (int i = 1; i < DIV_LATENCY; i++) shadow_q[i] <= shadow_q[i-1];
    end
  end

  // Result steering straight from the tail stage.
  always_comb begin
    res_valid_out           = '0;
    res_valid_out[tail.tag] = tail.valid;
  end

  assign res_quotient_out = div_quotient_in;
  assign res_dbz_out      = tail.valid & tail.dbz;

  // Occupancy: unpaused tail valid means the result was consumed this cycle.
  always_comb begin
    inflight_d = inflight_q;
    if (!div_pause_out)
      inflight_d = inflight_q + CNT_W'(gnt_vld) - CNT_W'(tail.valid);
  end

  // Occupancy register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) inflight_q <= '0;
    else           inflight_q <= inflight_d;
  end

  assign inflight_out = inflight_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural 7-stage divider and a
// scoreboard of expected results in issue order.
module tb_div_share_ctrl;
  import div_share_pkg::*;

  localparam int N  = 4;
  localparam int W  = 14;
  localparam int L  = 7;
  localparam int CW = $clog2(L + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid_in;
  logic [N*W-1:0]   req_dividend_in;
  logic [N*W-1:0]   req_divisor_in;
  logic [N-1:0]     req_ready_out;
  logic [N-1:0]     res_valid_out;
  logic [W-1:0]     res_quotient_out;
  logic             res_dbz_out;
  logic [N-1:0]     res_ready_in;
  logic [W-1:0]     div_dividend_out;
  logic [W-1:0]     div_divisor_out;
  logic             div_valid_out;
  logic             div_pause_out;
  logic [W-1:0]     div_quotient_in;
  logic [CW-1:0]    inflight_out;

  always #5 clk = ~clk;

  div_share_ctrl #(.NUM_REQ(N), .WIDTH(W), .DIV_LATENCY(L)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n),
    .req_valid_in     (req_valid_in),
    .req_dividend_in  (req_dividend_in),
    .req_divisor_in   (req_divisor_in),
    .req_ready_out    (req_ready_out),
    .res_valid_out    (res_valid_out),
    .res_quotient_out (res_quotient_out),
    .res_dbz_out      (res_dbz_out),
    .res_ready_in     (res_ready_in),
    .div_dividend_out (div_dividend_out),
    .div_divisor_out  (div_divisor_out),
    .div_valid_out    (div_valid_out),
    .div_pause_out    (div_pause_out),
    .div_quotient_in  (div_quotient_in),
    .inflight_out     (inflight_out)
  );

  // Restoring divider result: divisor 0 gives all ones.
  function automatic logic [W-1:0] qfn(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? {W{1'b1}} : a / b;
  endfunction

  // Behavioural divider: no reset, L stages, frozen by pause.
  logic [W-1:0] dpipe [L];
  always_ff @(posedge clk) begin
    if (!div_pause_out) begin
      dpipe[0] <= qfn(div_dividend_out, div_divisor_out);
      for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign div_quotient_in = dpipe[L-1];

  typedef struct {
    int           tag;
    logic [W-1:0] q;
    logic         dbz;
    int           icyc;
    int           ipc;
    bit           seen;
  } exp_t;

  exp_t           sb[$];
  logic [2*W-1:0] pend [N][$];
  int             glog[$];
  int             nchk = 0, nerr = 0, cyc = 0, pc = 0, since3 = 0;
  bit             fair_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int r);
    logic [2*W-1:0] op;
    if (pend[r].size() > 0) begin
      op = pend[r].pop_front();
      req_valid_in[r]            = 1'b1;
      req_dividend_in[r*W +: W]  = op[2*W-1:W];
      req_divisor_in[r*W +: W]   = op[W-1:0];
    end else begin
      req_valid_in[r] = 1'b0;
    end
  endtask

  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    pend[r].push_back({a, b});
    if (!req_valid_in[r]) load(r);
  endtask

  // One clock: check results and grants at negedge, advance requesters after posedge.
  task automatic cycle();
    logic [N-1:0] g;
    logic [W-1:0] a, b;
    @(negedge clk);
    chk("pause", div_pause_out, |(res_valid_out & ~res_ready_in));
    if (res_valid_out != '0) begin
      if (sb.size() == 0) chk("stray_result", res_valid_out, 0);
      else begin
        chk("res_tag", res_valid_out, 32'(1) << sb[0].tag);
        chk("res_quot", res_quotient_out, sb[0].q);
        chk("res_dbz", res_dbz_out, sb[0].dbz);
        if (!sb[0].seen) begin
          chk("latency", cyc - sb[0].icyc, L + pc - sb[0].ipc);
          sb[0].seen = 1'b1;
        end
        if ((res_valid_out & res_ready_in) != '0) void'(sb.pop_front());
      end
    end else begin
      chk("dbz_idle", res_dbz_out, 0);
    end
    g = req_ready_out;
    chk("ready_has_valid", g & ~req_valid_in, 0);
    chk("div_valid", div_valid_out, |g);
    if (div_pause_out) chk("no_grant_in_pause", g, 0);
    if (g != '0) chk("grant_onehot", $countones(g), 1);
    for (int r = 0; r < N; r++) begin
      if (g[r]) begin
        a = req_dividend_in[r*W +: W];
        b = req_divisor_in[r*W +: W];
        chk("div_dividend", div_dividend_out, a);
        chk("div_divisor", div_divisor_out, b);
        sb.push_back('{r, qfn(a, b), (b == '0), cyc, pc, 1'b0});
        glog.push_back(r);
        if (fair_on) begin
          if (r == 3) begin
            chk("fair_gap", since3 <= 3, 1);
            since3 = 0;
          end else since3++;
        end
      end
    end
    if (div_pause_out) pc++;
    @(posedge clk); #1;
    cyc++;
    for (int r = 0; r < N; r++) if (g[r]) load(r);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_div_valid"}, div_valid_out, 0);
    chk({tag, "_pause"}, div_pause_out, 0);
    chk({tag, "_req_ready"}, req_ready_out, 0);
    chk({tag, "_res_valid"}, res_valid_out, 0);
    chk({tag, "_dbz"}, res_dbz_out, 0);
    chk({tag, "_dividend"}, div_dividend_out, 0);
    chk({tag, "_divisor"}, div_divisor_out, 0);
    chk({tag, "_inflight"}, inflight_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, pstart, n3;
    rst_n           = 1'b0;
    req_valid_in    = '1;     // requests during reset must not be granted
    req_dividend_in = '1;
    req_divisor_in  = '1;
    res_ready_in    = '1;
    #12;
    chk_zero_outputs("reset");
    req_valid_in    = '0;
    rst_n           = 1'b1;
    @(posedge clk); #1;

    // Back-to-back, all four requesting, with a wrap back to requester 0.
    issue(0, 14'd16383, 14'd3);
    issue(1, 14'd50, 14'd5);
    issue(2, 14'd9, 14'd10);
    issue(3, 14'd1000, 14'd1);
    issue(0, 14'd7, 14'd2);
    repeat (4) cycle();
    chk("inflight_b2b", inflight_out, 4);
    repeat (9) cycle();
    chk("b2b_grants", glog.size(), 5);
    for (int i = 0; i < glog.size() && i < 5; i++) chk("b2b_order", glog[i], i % 4);
    chk("b2b_drained", sb.size(), 0);
    chk("b2b_inflight0", inflight_out, 0);
    glog.delete();

    // Single request.
    issue(0, 14'd100, 14'd7);
    repeat (10) cycle();
    chk("single_drained", sb.size(), 0);

    // Divide by zero.
    issue(2, 14'd1234, 14'd0);
    repeat (10) cycle();
    chk("dbz_drained", sb.size(), 0);

    // Backpressure on requester 1 with requests still queued behind it.
    issue(0, 14'd500, 14'd4);
    issue(1, 14'd77, 14'd7);
    issue(2, 14'd0, 14'd5);
    issue(3, 14'd16383, 14'd16383);
    for (int rd = 0; rd < 2; rd++)
      for (int r = 0; r < N; r++)
        issue(r, 14'($urandom_range(0, 16383)), 14'($urandom_range(0, 40)));
    res_ready_in[1] = 1'b0;
    pstart = pc;
    k = 0;
    while ((pc - pstart) < 3 && k < 40) begin
      cycle();
      k++;
    end
    res_ready_in[1] = 1'b1;
    chk("bp_no_timeout", k < 40, 1);
    chk("bp_pause_cycles", pc - pstart, 3);
    repeat (20) cycle();
    chk("bp_pause_total", pc - pstart, 3);
    chk("bp_drained", sb.size(), 0);

    // Reset with five ops in flight.
    issue(0, 14'd10, 14'd2);
    issue(1, 14'd20, 14'd3);
    issue(2, 14'd30, 14'd4);
    issue(3, 14'd40, 14'd5);
    issue(0, 14'd50, 14'd6);
    repeat (5) cycle();
    chk("inflight5", inflight_out, 5);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("midrst");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("post_rst_nores", res_valid_out, 0);
    end
    chk("post_rst_inflight", inflight_out, 0);
    glog.delete();

    // Fairness: requester 3 always valid, 0..2 come and go.
    for (int i = 0; i < 12; i++) issue(3, 14'(i * 37), 14'(i + 1));
    fair_on = 1'b1;
    since3  = 0;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) issue(i % 3, 14'($urandom_range(0, 16383)), 14'($urandom_range(1, 99)));
      cycle();
    end
    fair_on = 1'b0;
    repeat (30) cycle();
    n3 = 0;
    foreach (glog[i]) if (glog[i] == 3) n3++;
    chk("fair_all3", n3, 12);
    chk("fair_drained", sb.size(), 0);
    chk("final_inflight", inflight_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
